// File: rtl/alu_control_md_if.sv
// Bundle between decode/main control and alu_control_md: decode fields,
// operands, M-extension control, and the ALU opcode / stall / result outputs.
interface alu_control_md_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
);
    logic [1:0]        ALUOp;
    logic [6:0]        fun7;
    logic [2:0]        fun3;
    logic              op_valid;
    logic              md_flush;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [CTRL_W-1:0] Control_out;
    logic              illegal;
    logic              md_stall;
    logic              md_done;
    logic [XLEN-1:0]   md_result;
    logic [1:0]        md_state;   // debug view of the M-engine FSM state

    // Handshake: the decode slot presents an M op with op_valid=1 and keeps it
    // presented while md_stall=1; the op retires in the cycle md_done=1
    // (md_stall=0 there). md_flush aborts an op in flight without a done pulse.
    modport master (
        output ALUOp, fun7, fun3, op_valid, md_flush, src_a, src_b,
        input  Control_out, illegal, md_stall, md_done, md_result, md_state
    );

    modport slave (
        input  ALUOp, fun7, fun3, op_valid, md_flush, src_a, src_b,
        output Control_out, illegal, md_stall, md_done, md_result, md_state
    );
endinterface

// File: rtl/alu_control_md.sv
// RV32 ALU control: full R/I-type decode to a 5-bit ALU opcode plus an
// iterative shift-add multiplier / restoring divider for the M extension.
module alu_control_md #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_control_md_if.slave    bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;
    localparam logic [4:0] OP_MD   = 5'b10000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
    logic [XLEN-1:0]     opb_q, opb_d;      // multiplicand / divisor magnitude
    logic [XLEN-1:0]     a_raw_q, a_raw_d;  // original rs1 for divide-by-zero remainder
    logic [XLEN-1:0]     result_q, result_d;
    logic [2:0]          f3_q, f3_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic                bzero_q, bzero_d;

    logic [4:0]          base_op;
    logic [4:0]          ctrl;
    logic                ill;
    logic                is_md;
    logic                start;

    // fun3 mapping shared by R-type (fun7=0) and I-type ALU ops
    always_comb begin
        base_op = OP_ADD;
        case (bus.fun3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    end

    // Full decode; every unrecognised combination yields ADD with illegal set
    always_comb begin
        ctrl  = OP_ADD;
        ill   = 1'b0;
        is_md = 1'b0;
        case (bus.ALUOp)
            2'b00: ctrl = OP_ADD;
            2'b01: ctrl = OP_SUB;
            2'b10: begin
                if (bus.fun7 == F7_BASE) begin
                    ctrl = base_op;
                end else if (bus.fun7 == F7_ALT) begin
                    if (bus.fun3 == 3'b000)      ctrl = OP_SUB;
                    else if (bus.fun3 == 3'b101) ctrl = OP_SRA;
                    else                         ill  = 1'b1;
                end else if (bus.fun7 == F7_MD) begin
                    ctrl  = OP_MD;
                    is_md = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            default: begin
                // I-type: fun7 only qualifies the shift-immediates
                case (bus.fun3)
                    3'b001: begin
                        if (bus.fun7 == F7_BASE) ctrl = OP_SLL;
                        else                     ill  = 1'b1;
                    end
                    3'b101: begin
                        if (bus.fun7 == F7_BASE)     ctrl = OP_SRL;
                        else if (bus.fun7 == F7_ALT) ctrl = OP_SRA;
                        else                         ill  = 1'b1;
                    end
                    default: ctrl = base_op;
                endcase
            end
        endcase
        if (ill) ctrl = OP_ADD;
    end

    assign bus.Control_out = CTRL_W'(ctrl);
    assign bus.illegal     = ill;

    // No issue while reset is held, during a flush, or outside IDLE
    assign start = bus.op_valid & is_md & (state_q == S_IDLE) & ~bus.md_flush & rst_n;

    // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    assign a_sgn = (bus.fun3 == 3'b001) | (bus.fun3 == 3'b010) |
                   (bus.fun3 == 3'b100) | (bus.fun3 == 3'b110);
    assign b_sgn = (bus.fun3 == 3'b001) | (bus.fun3 == 3'b100) | (bus.fun3 == 3'b110);
    assign a_neg = a_sgn & bus.src_a[XLEN-1];
    assign b_neg = b_sgn & bus.src_b[XLEN-1];
    assign mag_a = a_neg ? -bus.src_a : bus.src_a;
    assign mag_b = b_neg ? -bus.src_b : bus.src_b;

    // One iteration of shift-add multiply and of restoring divide
    logic            is_div;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    assign is_div    = f3_q[2];
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_sub   = div_shift[XLEN-1:0] - opb_q;

    // Sign fixup and half/quotient/remainder selection used in FIX
    logic                prod_neg;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     mul_res, div_res, quo, rem;
    assign prod_neg = neg_a_q ^ neg_b_q;
    assign prod_fix = prod_neg ? -acc_q : acc_q;
    assign mul_res  = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    assign quo      = acc_q[XLEN-1:0];
    assign rem      = acc_q[2*XLEN-1:XLEN];
    assign div_res  = bzero_q ? (f3_q[1] ? a_raw_q : '1)
                              : (f3_q[1] ? (neg_a_q ? -rem : rem)
                                         : (prod_neg ? -quo : quo));

    // M-engine next state and datapath updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        a_raw_d  = a_raw_q;
        result_d = result_q;
        f3_d     = f3_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        bzero_d  = bzero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = CW'(XLEN - 1);
                    acc_d   = {{XLEN{1'b0}}, mag_a};
                    opb_d   = mag_b;
                    a_raw_d = bus.src_a;
                    f3_d    = bus.fun3;
                    neg_a_d = a_neg;
                    neg_b_d = b_neg;
                    bzero_d = (bus.src_b == '0);
                end
            end
            S_CALC: begin
                if (bus.md_flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div)
                        acc_d = {div_ge ? div_sub : div_shift[XLEN-1:0],
                                 acc_q[XLEN-2:0], div_ge};
                    else
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                if (bus.md_flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = is_div ? div_res : mul_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            a_raw_q  <= '0;
            result_q <= '0;
            f3_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            a_raw_q  <= a_raw_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            bzero_q  <= bzero_d;
        end
    end

    assign bus.md_stall  = start | (state_q == S_CALC) | (state_q == S_FIX);
    assign bus.md_done   = (state_q == S_DONE);
    assign bus.md_result = result_q;
    assign bus.md_state  = state_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode vectors, M-op results and
// timing, divide corners, flush, asynchronous reset and back-to-back issue.
module tb_alu_control_md;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 5;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_control_md_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus();

    alu_control_md #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    // Drive one decode vector and compare opcode and illegal flag
    task automatic dec(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [4:0] ectl, input logic eill, input string tag);
        bus.ALUOp = op;
        bus.fun7  = f7;
        bus.fun3  = f3;
        #1;
        check({tag, "_ctl"}, 32'(bus.Control_out), 32'(ectl));
        check_bit({tag, "_ill"}, bus.illegal, eill);
    endtask

    // Issue an M op in the current (IDLE) cycle and follow it to md_done.
    // Leaves op_valid high in the DONE cycle.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
        int stall_cnt;
        int cycle;
        bit done_seen;
        bus.ALUOp    = 2'b10;
        bus.fun7     = 7'b0000001;
        bus.fun3     = f3;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.op_valid = 1'b1;
        bus.md_flush = 1'b0;
        #1;
        check_bit({tag, "_issue_stall"}, bus.md_stall, 1'b1);
        stall_cnt = bus.md_stall ? 1 : 0;
        cycle     = 1;
        done_seen = 1'b0;
        while (!done_seen && cycle < 100) begin
            @(posedge clk);
            #1;
            cycle++;
            bus.src_a = $urandom;
            bus.src_b = $urandom;
            if (bus.md_done) done_seen = 1'b1;
            else if (bus.md_stall) stall_cnt++;
        end
        check({tag, "_done_cycle"}, cycle, 35);
        check({tag, "_stall_cycles"}, stall_cnt, 34);
        check_bit({tag, "_done_nostall"}, bus.md_stall, 1'b0);
        check({tag, "_result"}, bus.md_result, expv);
    endtask

    // One idle cycle after an op: no further done, result held
    task automatic idle_step(input logic [31:0] hold, input string tag);
        bus.op_valid = 1'b0;
        @(posedge clk);
        #1;
        check_bit({tag, "_done_pulse"}, bus.md_done, 1'b0);
        check({tag, "_hold"}, bus.md_result, hold);
    endtask

    initial begin
        int dones;
        bus.ALUOp    = 2'b00;
        bus.fun7     = 7'b0;
        bus.fun3     = 3'b0;
        bus.op_valid = 1'b0;
        bus.md_flush = 1'b0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        #1;
        check_bit("rst_stall", bus.md_stall, 1'b0);
        check_bit("rst_done", bus.md_done, 1'b0);
        check("rst_result", bus.md_result, 32'h0);
        check("rst_state", 32'(bus.md_state), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Decode vectors
        dec(2'b00, 7'b0110011, 3'b101, 5'b00010, 1'b0, "ld_add");
        dec(2'b01, 7'b0000000, 3'b111, 5'b00110, 1'b0, "br_sub");
        dec(2'b10, 7'b0000000, 3'b000, 5'b00010, 1'b0, "r_add");
        dec(2'b10, 7'b0000000, 3'b001, 5'b00100, 1'b0, "r_sll");
        dec(2'b10, 7'b0000000, 3'b010, 5'b01000, 1'b0, "r_slt");
        dec(2'b10, 7'b0000000, 3'b011, 5'b01001, 1'b0, "r_sltu");
        dec(2'b10, 7'b0000000, 3'b100, 5'b00011, 1'b0, "r_xor");
        dec(2'b10, 7'b0000000, 3'b101, 5'b00101, 1'b0, "r_srl");
        dec(2'b10, 7'b0000000, 3'b110, 5'b00001, 1'b0, "r_or");
        dec(2'b10, 7'b0000000, 3'b111, 5'b00000, 1'b0, "r_and");
        dec(2'b10, 7'b0100000, 3'b000, 5'b00110, 1'b0, "r_sub");
        dec(2'b10, 7'b0100000, 3'b101, 5'b00111, 1'b0, "r_sra");
        dec(2'b10, 7'b0100000, 3'b111, 5'b00010, 1'b1, "r_alt_bad");
        dec(2'b10, 7'b0000001, 3'b011, 5'b10000, 1'b0, "r_md");
        dec(2'b10, 7'b0000010, 3'b000, 5'b00010, 1'b1, "r_f7_bad");
        dec(2'b11, 7'b0100000, 3'b000, 5'b00010, 1'b0, "i_addi");
        dec(2'b11, 7'b0100000, 3'b101, 5'b00111, 1'b0, "i_srai");
        dec(2'b11, 7'b0000000, 3'b101, 5'b00101, 1'b0, "i_srli");
        dec(2'b11, 7'b0000000, 3'b001, 5'b00100, 1'b0, "i_slli");
        dec(2'b11, 7'b0100000, 3'b001, 5'b00010, 1'b1, "i_slli_bad");
        dec(2'b11, 7'b0000011, 3'b101, 5'b00010, 1'b1, "i_shr_bad");
        dec(2'b11, 7'b1111111, 3'b110, 5'b00001, 1'b0, "i_ori");
        dec(2'b11, 7'b0000001, 3'b010, 5'b01000, 1'b0, "i_slti");
        dec(2'b11, 7'b1010101, 3'b111, 5'b00000, 1'b0, "i_andi");
        check_bit("dec_no_stall", bus.md_stall, 1'b0);

        // MUL family
        run_md(3'b000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, "mul");
        idle_step(32'hFFFFFFF9, "mul_idle");
        run_md(3'b001, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, "mulh");
        idle_step(32'hFFFFFFFF, "mulh_idle");
        run_md(3'b011, 32'hFFFFFFFF, 32'd7, 32'h00000006, "mulhu");
        idle_step(32'h00000006, "mulhu_idle");
        run_md(3'b010, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, "mulhsu");
        idle_step(32'hFFFFFFFF, "mulhsu_idle");

        // Divide family and corners
        run_md(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2");
        idle_step(32'hFFFFFFFD, "div_idle");
        run_md(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2");
        idle_step(32'hFFFFFFFF, "rem_idle");
        run_md(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, "divu");
        idle_step(32'h7FFFFFFC, "divu_idle");
        run_md(3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, "remu");
        idle_step(32'h00000001, "remu_idle");
        run_md(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
        idle_step(32'hFFFFFFFF, "divu_by0_idle");
        run_md(3'b110, 32'd5, 32'd0, 32'h00000005, "rem_by0");
        idle_step(32'h00000005, "rem_by0_idle");
        run_md(3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, "div_m5_by0");
        idle_step(32'hFFFFFFFF, "div_m5_by0_idle");
        run_md(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        idle_step(32'h80000000, "div_ovf_idle");
        run_md(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
        idle_step(32'h00000000, "rem_ovf_idle");
        run_md(3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, "div_100_m7");
        idle_step(32'hFFFFFFF2, "div_100_m7_idle");
        run_md(3'b110, 32'd100, 32'hFFFFFFF9, 32'h00000002, "rem_100_m7");
        idle_step(32'h00000002, "rem_100_m7_idle");

        // Back-to-back: op_valid stays high through DONE, second issues next cycle
        run_md(3'b000, 32'd3, 32'd5, 32'd15, "b2b_first");
        @(posedge clk);
        #1;
        run_md(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "b2b_second");
        idle_step(32'hFFFFFFFE, "b2b_idle");

        // Flush at CALC iteration 5
        bus.ALUOp    = 2'b10;
        bus.fun7     = 7'b0000001;
        bus.fun3     = 3'b100;
        bus.src_a    = 32'd100;
        bus.src_b    = 32'd7;
        bus.op_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("flush_pre_state", 32'(bus.md_state), 32'd1);
        bus.md_flush = 1'b1;
        bus.op_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.md_flush = 1'b0;
        check("flush_state", 32'(bus.md_state), 32'd0);
        check_bit("flush_stall", bus.md_stall, 1'b0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.md_done) dones++;
        end
        check("flush_no_done", dones, 0);
        check("flush_result_kept", bus.md_result, 32'hFFFFFFFE);

        // Flush in the same cycle as a would-be start
        bus.op_valid = 1'b1;
        bus.md_flush = 1'b1;
        #1;
        check_bit("flush_start_stall", bus.md_stall, 1'b0);
        @(posedge clk);
        #1;
        check("flush_start_state", 32'(bus.md_state), 32'd0);
        bus.md_flush = 1'b0;
        bus.op_valid = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset at CALC iteration 10, op_valid held
        bus.fun3     = 3'b000;
        bus.src_a    = 32'hFFFFFFFF;
        bus.src_b    = 32'd7;
        bus.op_valid = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("rst_mid_pre_state", 32'(bus.md_state), 32'd1);
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid_stall", bus.md_stall, 1'b0);
        check_bit("rst_mid_done", bus.md_done, 1'b0);
        check("rst_mid_result", bus.md_result, 32'h0);
        check("rst_mid_state", 32'(bus.md_state), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_md(3'b000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, "mul_after_rst");
        idle_step(32'hFFFFFFF9, "mul_after_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
Next-generation ALU control for the RV32 core. It fully decodes R-type and I-type ALU ops into a 5-bit ALU opcode, with a defined output for every input combination. It adds an iterative multiply/divide sequencer for the M extension, with a stall handshake to the single-cycle datapath. It sits between main control/decode and the ALU; the ALU ignores Control_out when it equals MD.

Parameters:
XLEN, 32, datapath/operand width; iteration count of the M engine
CTRL_W, 5, Control_out width (fixed encoding below; must be >=5)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
ALUOp  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type ALU
fun7  in  7  instr[31:25]
fun3  in  3  instr[14:12]
op_valid  in  1  decode slot holds a valid instruction this cycle
md_flush  in  1  synchronous abort of in-flight M op
src_a  in  XLEN  rs1 value
src_b  in  XLEN  rs2 value
Control_out  out  CTRL_W  ALU opcode (combinational)
illegal  out  1  unrecognised ALUOp/fun7/fun3 (combinational)
md_stall  out  1  hold PC/pipeline (combinational)
md_done  out  1  one-cycle pulse, md_result valid
md_result  out  XLEN  M-op result, holds until next done

Behaviour:
- Encoding: AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, SRA 00111, SLT 01000, SLTU 01001, MD 10000. Legacy 4-bit codes for AND/OR/ADD/SUB are preserved.
- ALUOp 00 -> ADD; 01 -> SUB.
- ALUOp 10, fun7=0000000: fun3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- ALUOp 10, fun7=0100000: 000 SUB, 101 SRA; other fun3 are illegal.
- ALUOp 10, fun7=0000001 -> MD.
- ALUOp 11: fun3 decoded as for R-type, but 000 is always ADD. Shifts require fun7=0000000 (SRLI/SLLI) or 0100000 with fun3=101 (SRAI); fun7 is ignored for the non-shift fun3 values.
- Any other combination: Control_out=ADD, illegal=1. No latches; fully combinational decode.
- start = op_valid & is_MD & state==IDLE & !md_flush.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on start. Latch operands, fun3 and sign flags. Operands are converted to magnitudes per op signedness: MULH both signed, MULHSU rs1 signed only, DIV/REM signed.
  - CALC: XLEN cycles, counter XLEN-1 down to 0. Multiply is shift-add into a 2*XLEN product. Divide is restoring, one quotient bit per cycle.
  - CALC -> FIX when counter hits 0.
  - FIX: 1 cycle. Apply sign negation, select the low/high product half or quotient/remainder, register md_result.
  - FIX -> DONE.
  - DONE: 1 cycle, md_done=1, md_stall=0 so the held instruction retires. DONE -> IDLE unconditionally; a new start cannot occur in DONE.
- md_stall = (IDLE & start) | CALC | FIX.
- Latency: issue cycle plus XLEN+1 stalled cycles; md_done is asserted XLEN+2 cycles after issue. Latency is fixed and independent of operand values.
- src_a/src_b changes after issue are ignored.
- Divide by zero: quotient all-ones (DIV and DIVU), remainder = original rs1; sign fixup is bypassed.
- Overflow DIV(-2^(XLEN-1), -1): quotient -2^(XLEN-1), remainder 0.
- Remainder sign follows the dividend; quotient sign is the XOR of the operand signs.
- md_flush in CALC/FIX: next state IDLE, no md_done, md_result unchanged. md_flush in the same cycle as a would-be start: no start. md_flush in DONE: no effect.
- Reset (asynchronous, any state): state=IDLE, counter=0, md_done=0, md_result=0, internal product/quotient regs=0. md_stall/illegal/Control_out follow the inputs (combinational).
- op_valid low during CALC does not abort the op; only md_flush or rst_n aborts.

Test Plan:
- Decode sweep: all 256 {ALUOp,fun7 variants,fun3} -> exact codes. Examples: 10/0100000/000 -> 00110; 11/0100000/101 -> 00111; 11/0100000/000 -> 00010; 10/0000010/000 -> illegal=1, 00010.
- MUL family, XLEN=32, a=0xFFFFFFFF, b=7: MUL -> 0xFFFFFFF9, MULH -> 0xFFFFFFFF, MULHU -> 0x00000006, MULHSU -> 0xFFFFFFFF. md_stall high exactly 34 cycles, md_done at cycle 35.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- Corners: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- rst_n low at CALC iteration 10 -> md_stall/md_done/md_result immediately 0. After release with op_valid held -> restarts with full 34-cycle stall.
- md_flush at CALC iteration 5 -> IDLE next cycle, no md_done, md_result keeps prior value. Back-to-back MULs -> second issues the cycle after DONE, both results correct.
